// File: rtl/mem_bus_arbiter.sv
// Shares the single core memory bus between instruction fetch and the MEM-stage data path.
// Define ARB_FAIR_EN for round-robin arbitration; otherwise the data side always wins a conflict.
module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,

    output logic                busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       owner;
    logic       drop;
    logic       if_grantable;
    logic       grant_any;
    logic       grant_d;

    // A fetch raised in the same cycle as a redirect is stale and never granted.
    assign if_grantable = if_req & ~if_flush;
    assign grant_any    = d_req | if_grantable;

`ifdef ARB_FAIR_EN
    logic last_owner;

    assign grant_d = d_req & (~if_grantable | (last_owner == OWNER_IF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWNER_IF;
        end else if (state == S_IDLE && grant_any) begin
            last_owner <= grant_d ? OWNER_D : OWNER_IF;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_BUS;
            S_BUS:   if (bus_ack) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus-side request registers stay stable for the whole transaction and hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWNER_IF;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
        end else if (state == S_IDLE && grant_any) begin
            if (grant_d) begin
                owner     <= OWNER_D;
                bus_we    <= d_we;
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
                bus_be    <= d_be;
            end else begin
                owner     <= OWNER_IF;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_be    <= '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (state == S_RESP) begin
            drop <= 1'b0;
        end else if (state == S_BUS && owner == OWNER_IF && if_flush) begin
            drop <= 1'b1;
        end
    end

    // Read data is captured even for a dropped fetch; only the ack is withheld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (state == S_BUS && bus_ack) begin
            if (owner == OWNER_IF) begin
                if_rdata <= bus_rdata;
            end else if (!bus_we) begin
                d_rdata <= bus_rdata;
            end
        end
    end

    assign bus_req = (state == S_BUS);
    assign busy    = (state != S_IDLE);
    assign if_ack  = (state == S_RESP) && (owner == OWNER_IF) && !drop && !if_flush;
    assign d_ack   = (state == S_RESP) && (owner == OWNER_D);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level reference model checked every cycle
// plus directed scenarios with hand-computed expectations (works with or without ARB_FAIR_EN).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, bus_ack = 1'b0;
    logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, bus_rdata = '0;
    logic [7:0]  d_be = '0;
    logic        if_ack, d_ack, bus_req, bus_we, busy;
    logic [63:0] if_rdata, d_rdata, bus_addr, bus_wdata;
    logic [7:0]  bus_be;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record and where it is in its life.
    logic        m_on_bus = 0, m_in_resp = 0, m_is_data = 0, m_dropped = 0, m_last_data = 0;
    logic        m_we = 0, m_want_if = 0, m_take_d = 0;
    logic [63:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
    logic [7:0]  m_be = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_on_bus = 0; m_in_resp = 0; m_is_data = 0; m_dropped = 0; m_last_data = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_if_rdata = 0; m_d_rdata = 0;
        end else if (m_in_resp) begin
            m_in_resp = 0;
            m_dropped = 0;
        end else if (m_on_bus) begin
            if (!m_is_data && if_flush) m_dropped = 1;
            if (bus_ack) begin
                if (!m_is_data) m_if_rdata = bus_rdata;
                else if (!m_we) m_d_rdata = bus_rdata;
                m_on_bus  = 0;
                m_in_resp = 1;
            end
        end else begin
            m_want_if = if_req && !if_flush;
`ifdef ARB_FAIR_EN
            m_take_d = d_req && (!m_want_if || !m_last_data);
`else
            m_take_d = d_req;
`endif
            if (m_take_d) begin
                m_is_data = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
                m_on_bus = 1; m_last_data = 1;
            end else if (m_want_if) begin
                m_is_data = 0; m_we = 0; m_addr = if_addr; m_wdata = 0; m_be = 8'hFF;
                m_on_bus = 1; m_last_data = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checkOutput("bus_req",   bus_req,   m_on_bus);
            checkOutput("busy",      busy,      m_on_bus | m_in_resp);
            checkOutput("if_ack",    if_ack,    m_in_resp && !m_is_data && !m_dropped && !if_flush);
            checkOutput("d_ack",     d_ack,     m_in_resp && m_is_data);
            checkOutput("bus_we",    bus_we,    m_we);
            checkOutput("bus_addr",  bus_addr,  m_addr);
            checkOutput("bus_wdata", bus_wdata, m_wdata);
            checkOutput("bus_be",    bus_be,    m_be);
            checkOutput("if_rdata",  if_rdata,  m_if_rdata);
            checkOutput("d_rdata",   d_rdata,   m_d_rdata);
        end
    end

    logic [7:0] ack_who[$];
    int         ack_cyc[$];
    int         bus_req_cycles = 0;

    initial forever begin
        @(negedge clk);
        if (if_ack) begin ack_who.push_back("I"); ack_cyc.push_back(cyc); end
        if (d_ack)  begin ack_who.push_back("D"); ack_cyc.push_back(cyc); end
        if (bus_req) bus_req_cycles++;
    end

    // Bus slave: acks after ack_delay wait cycles with rsp_data.
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        rsp_en = 1'b1;
    logic [63:0] rsp_data = '0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rsp_en) begin
            if (bus_req && !rst) begin
                if (wcnt >= ack_delay) begin
                    bus_ack = 1'b1; bus_rdata = rsp_data; wcnt = 0;
                end else begin
                    bus_ack = 1'b0; wcnt++;
                end
            end else begin
                bus_ack = 1'b0; wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic ir, input logic [63:0] ia, input logic dr, input logic dwe,
                                 input logic [63:0] da, input logic [63:0] dwd, input logic [7:0] dbe);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ack_who.delete();
        ack_cyc.delete();
        bus_req_cycles = 0;
    endtask

    task automatic wait_bus_req(input int max, input string tag);
        int k = 0;
        while (!bus_req && k < max) begin tick(1); k++; end
        checkOutput(tag, bus_req, 1'b1);
    endtask

    task automatic wait_acks(input int n, input int max, input string tag);
        int k = 0;
        while (ack_who.size() < n && k < max) begin tick(1); k++; end
        checkOutput(tag, 64'(ack_who.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int k = 0;
        while (busy && k < max) begin tick(1); k++; end
        checkOutput(tag, busy, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    function automatic logic [7:0] who_at(input int i);
        if (i < ack_who.size()) return ack_who[i];
        return "?";
    endfunction

    function automatic int cyc_at(input int i);
        if (i < ack_cyc.size()) return ack_cyc[i];
        return -100;
    endfunction

    initial begin
        #2;
        rst = 1'b1;
        chk_en = 1'b1;
        #1;
        checkOutput("rst_busy",     busy,     1'b0);
        checkOutput("rst_bus_req",  bus_req,  1'b0);
        checkOutput("rst_bus_addr", bus_addr, 64'h0);
        checkOutput("rst_if_rdata", if_rdata, 64'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick(1);

        // Single fetch, ack on first bus cycle.
        clear_log();
        ack_delay = 0; rsp_data = 64'h13;
        applyStimulus(1, 64'h8000_0000, 0, 0, 0, 0, 0);
        wait_bus_req(5, "t1_grant");
        checkOutput("t1_bus_be",   bus_be,   8'hFF);
        checkOutput("t1_bus_we",   bus_we,   1'b0);
        checkOutput("t1_bus_addr", bus_addr, 64'h8000_0000);
        wait_acks(1, 10, "t1_ack_seen");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_if_rdata", if_rdata, 64'h13);
        checkOutput("t1_who", who_at(0), "I");
        tick(3);
        checkOutput("t1_ack_count", ack_who.size(), 1);

        // Store with three wait states.
        clear_log();
        ack_delay = 3; rsp_data = 64'hFFFF_0000_FFFF_0000;
        applyStimulus(0, 0, 1, 1, 64'h100, 64'hDEAD_BEEF, 8'h0F);
        wait_bus_req(5, "t2_grant");
        checkOutput("t2_bus_we",    bus_we,    1'b1);
        checkOutput("t2_bus_addr",  bus_addr,  64'h100);
        checkOutput("t2_bus_wdata", bus_wdata, 64'hDEAD_BEEF);
        checkOutput("t2_bus_be",    bus_be,    8'h0F);
        wait_acks(1, 20, "t2_ack_seen");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(3);
        checkOutput("t2_bus_cycles", bus_req_cycles, 4);
        checkOutput("t2_ack_count",  ack_who.size(), 1);
        checkOutput("t2_who",        who_at(0), "D");
        checkOutput("t2_d_rdata",    d_rdata, 64'h0);

        // Conflict with both requests held for three transactions, from a fresh reset.
        apply_reset();
        clear_log();
        ack_delay = 0; rsp_data = 64'h55AA;
        applyStimulus(1, 64'h8000_0040, 1, 0, 64'h200, 0, 8'hF0);
        wait_acks(3, 30, "t3_ack_seen");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_who0", who_at(0), "D");
`ifdef ARB_FAIR_EN
        checkOutput("t3_who1", who_at(1), "I");
        checkOutput("t3_if_rdata", if_rdata, 64'h55AA);
`else
        checkOutput("t3_who1", who_at(1), "D");
        checkOutput("t3_if_rdata", if_rdata, 64'h0);
`endif
        checkOutput("t3_who2", who_at(2), "D");
        checkOutput("t3_d_rdata", d_rdata, 64'h55AA);
        tick(3);
        checkOutput("t3_ack_count", ack_who.size(), 3);

        // Fetch raised together with a redirect is not granted.
        clear_log();
        applyStimulus(1, 64'h8000_00C0, 0, 0, 0, 0, 0);
        if_flush = 1'b1;
        tick(1);
        checkOutput("t4_flush_ignored", busy, 1'b0);
        if_flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(1);

        // Flush during the bus phase: transaction finishes, no if_ack.
        clear_log();
        ack_delay = 2; rsp_data = 64'hABCD;
        applyStimulus(1, 64'h8000_0080, 0, 0, 0, 0, 0);
        wait_bus_req(5, "t4_grant");
        if_flush = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(1);
        if_flush = 1'b0;
        wait_idle(20, "t4_idle");
        tick(1);
        checkOutput("t4_no_if_ack",   ack_who.size(), 0);
        checkOutput("t4_bus_cycles",  bus_req_cycles, 3);
        ack_delay = 0; rsp_data = 64'h77;
        applyStimulus(0, 0, 1, 0, 64'h300, 0, 8'hFF);
        wait_acks(1, 10, "t4_d_ack_seen");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_who",     who_at(0), "D");
        checkOutput("t4_d_rdata", d_rdata, 64'h77);
        tick(2);

        // Reset asserted mid-transaction, with a late bus_ack during reset.
        clear_log();
        ack_delay = 5; rsp_data = 64'h99;
        applyStimulus(0, 0, 1, 1, 64'h400, 64'h1234, 8'hFF);
        wait_bus_req(5, "t5_grant");
        #3;
        rst = 1'b1;
        rsp_en = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t5_bus_req_drop", bus_req, 1'b0);
        checkOutput("t5_busy_drop",    busy,    1'b0);
        @(posedge clk);
        #1;
        bus_ack = 1'b1;
        bus_rdata = 64'hBAD;
        tick(1);
        bus_ack = 1'b0;
        rst = 1'b0;
        rsp_en = 1'b1;
        tick(4);
        checkOutput("t5_no_acks", ack_who.size(), 0);
        checkOutput("t5_busy",    busy,    1'b0);
        checkOutput("t5_d_rdata", d_rdata, 64'h0);

        // Back-to-back fetches with the request held continuously.
        clear_log();
        ack_delay = 0; rsp_data = 64'h6F;
        applyStimulus(1, 64'h8000_0100, 0, 0, 0, 0, 0);
        wait_acks(3, 20, "t6_ack_seen");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_spacing01", cyc_at(1) - cyc_at(0), 3);
        checkOutput("t6_spacing12", cyc_at(2) - cyc_at(1), 3);
        checkOutput("t6_who2",      who_at(2), "I");
        tick(3);
        checkOutput("t6_ack_count", ack_who.size(), 3);
        checkOutput("t6_if_rdata",  if_rdata, 64'h6F);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
